// File: rtl/risc_pack.sv
// Shared types for the qrisc32 memory arbiter: FSM state, transaction owner
// and the registered memory request bundle.
package risc_pack;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        D_BUSY
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int STARV_LIMIT_DEF = 4;

endpackage

// File: rtl/qrisc32_mem_arb.sv
// Single-port memory arbiter for qrisc32: fetch vs data, stall generation and
// stale-fetch dropping. Optional watchdog under QRISC32_MEM_ARB_TIMEOUT_EN.
module qrisc32_mem_arb
    import risc_pack::*;
#(
    parameter int STARV_LIMIT    = STARV_LIMIT_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        pipe_stall,
    output logic        bus_error
);
    localparam int SC_W = $clog2(STARV_LIMIT + 1);

    arb_state_t      state, state_nxt;
    arb_owner_t      winner, busy_owner;
    mem_req_t        win_req, mem_r;
    logic [SC_W-1:0] starv_cnt;
    logic            grant_if, grant_d, done, timeout, finish, drop;
    logic [31:0]     rsp_data;

    assign done       = (state != IDLE) & mem_ready;
    assign finish     = done | timeout;
    assign busy_owner = (state == IF_BUSY) ? OWN_IF : OWN_D;
    assign rsp_data   = done ? mem_rdata : 32'h0;

    // Data wins unless absent or the fetch has been starved to the limit;
    // a flush only blocks the fetch side of the pick.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        winner    = OWN_D;
        win_req   = '{we: d_we, addr: d_addr, wdata: d_wdata};
        case (state)
            IDLE: begin
                grant_if = if_req & ~flush &
                           (~d_req | (starv_cnt == SC_W'(STARV_LIMIT)));
                grant_d  = d_req & ~grant_if;
                if (grant_if) begin
                    winner  = OWN_IF;
                    win_req = '{we: 1'b0, addr: if_addr, wdata: 32'h0};
                end
                if (grant_if | grant_d)
                    state_nxt = (winner == OWN_IF) ? IF_BUSY : D_BUSY;
            end
            default: if (finish) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_r     <= '0;
            mem_req   <= 1'b0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
            starv_cnt <= '0;
            drop      <= 1'b0;
        end else begin
            if_gnt    <= grant_if;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;

            if (grant_if | grant_d) begin
                mem_req <= 1'b1;
                mem_r   <= win_req;
            end else if (finish) begin
                mem_req <= 1'b0;
            end

            if (state == IDLE) begin
                if (grant_if || !if_req)
                    starv_cnt <= '0;
                else if (grant_d && starv_cnt != SC_W'(STARV_LIMIT))
                    starv_cnt <= starv_cnt + 1'b1;
            end

            // A redirect seen at any point of a fetch kills its response.
            if (finish && busy_owner == OWN_IF) begin
                if_rvalid <= ~(drop | flush);
                if_rdata  <= rsp_data;
                drop      <= 1'b0;
            end else if (state == IF_BUSY && flush) begin
                drop <= 1'b1;
            end

            if (finish && busy_owner == OWN_D) begin
                d_rvalid <= 1'b1;
                d_rdata  <= rsp_data;
            end
        end
    end

`ifdef QRISC32_MEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            bus_error_r;

    assign timeout   = (state != IDLE) & ~mem_ready &
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign bus_error = bus_error_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            bus_error_r <= 1'b0;
        end else begin
            bus_error_r <= timeout;
            if (state == IDLE || mem_ready || timeout)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    // Watchdog absent: the limit is never negative, so this is a constant 0.
    assign bus_error = (TIMEOUT_CYCLES < 0);
`endif

    assign mem_we     = mem_r.we;
    assign mem_addr   = mem_r.addr;
    assign mem_wdata  = mem_r.wdata;
    assign pipe_stall = (d_req & ~d_rvalid) | (state == D_BUSY);

endmodule

// File: tb/tb_qrisc32_mem_arb.sv
// Self-checking bench for qrisc32_mem_arb: arbitration table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_qrisc32_mem_arb;
    import risc_pack::*;

    localparam int SL = 4;
    localparam int TO = 8;
`ifdef QRISC32_MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, flush, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, d_rvalid, mem_req, mem_we, pipe_stall, bus_error;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qrisc32_mem_arb #(.STARV_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid), .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pipe_stall(pipe_stall), .bus_error(bus_error)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        if_req = 0; flush = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clr_in();
        tick();
        tick();
        reset_n = 1;
    endtask

    typedef struct {
        logic        if_req, d_req, d_we, flush;
        logic        exp_gnt, exp_req, exp_we;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[7];

    // reference model: owner 0 = none, 1 = fetch, 2 = data
    int          m_own, m_starv, m_wait;
    bit          m_drop, m_we;
    logic [31:0] m_addr, m_wdata, m_rd;
    bit          e_req, e_gnt, e_irv, e_drv, e_berr;
    logic [31:0] e_ird, e_drd;

    byte         got[10];
    string       exp_seq;
    int          n;

    initial begin
        vecs[0] = '{1, 0, 0, 0, 1, 1, 0, 32'h1000};
        vecs[1] = '{0, 1, 0, 0, 0, 1, 0, 32'h2000};
        vecs[2] = '{1, 1, 1, 0, 0, 1, 1, 32'h2000};
        vecs[3] = '{1, 0, 0, 1, 0, 0, 0, 32'h0};
        vecs[4] = '{1, 1, 0, 1, 0, 1, 0, 32'h2000};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 32'h0};
        vecs[6] = '{0, 1, 1, 1, 0, 1, 1, 32'h2000};

        // reset state
        do_reset();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_bus", {mem_we, mem_addr | mem_wdata}, 0);
        check("rst_pulses", {if_gnt, if_rvalid, d_rvalid, bus_error}, 0);
        check("rst_rdata", if_rdata | d_rdata, 0);
        #1 check("rst_stall", pipe_stall, 0);

        // single-cycle arbitration table
        for (int i = 0; i < 7; i++) begin
            do_reset();
            if_req = vecs[i].if_req; d_req = vecs[i].d_req;
            d_we = vecs[i].d_we; flush = vecs[i].flush;
            if_addr = 32'h1000; d_addr = 32'h2000; d_wdata = 32'h55;
            #1 check("vec_stall", pipe_stall, vecs[i].d_req);
            tick();
            check("vec_gnt", if_gnt, vecs[i].exp_gnt);
            check("vec_req", mem_req, vecs[i].exp_req);
            check("vec_we", mem_we, vecs[i].exp_we);
            check("vec_addr", mem_addr, vecs[i].exp_addr);
            clr_in(); mem_ready = 1;
            tick();
            mem_ready = 0;
            tick();
        end

        // zero-wait data read
        do_reset();
        d_req = 1; d_addr = 32'h100;
        #1 check("rd_stall0", pipe_stall, 1);
        tick();
        check("rd_mem_req", mem_req, 1);
        check("rd_mem_addr", mem_addr, 32'h100);
        check("rd_rvalid_early", d_rvalid, 0);
        mem_ready = 1; mem_rdata = 32'h12345678;
        #1 check("rd_stall1", pipe_stall, 1);
        tick();
        check("rd_rvalid", d_rvalid, 1);
        check("rd_rdata", d_rdata, 32'h12345678);
        check("rd_mem_req_off", mem_req, 0);
        d_req = 0; mem_ready = 0;
        #1 check("rd_stall_rel", pipe_stall, 0);
        tick();
        check("rd_rvalid_pulse", d_rvalid, 0);

        // contention with starvation guard, zero-wait memory
        do_reset();
        if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h100; mem_ready = 1;
        n = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            tick();
            if (mem_req) begin
                got[n] = if_gnt ? "I" : "D";
                n++;
            end
        end
        check("cont_grants", n, 10);
        exp_seq = "DDDDIDDDDI";
        for (int i = 0; i < n; i++) check("cont_order", got[i], exp_seq[i]);

        // flush during a fetch, then a clean fetch
        do_reset();
        if_req = 1; if_addr = 32'h40;
        tick();
        check("fl_gnt", if_gnt, 1);
        check("fl_addr", mem_addr, 32'h40);
        if_req = 0; flush = 1;
        tick();
        flush = 0;
        tick();
        tick();
        mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
        tick();
        check("fl_dropped", if_rvalid, 0);
        check("fl_mem_req", mem_req, 0);
        mem_ready = 0; if_req = 1; if_addr = 32'h80;
        tick();
        check("fl2_gnt", if_gnt, 1);
        check("fl2_addr", mem_addr, 32'h80);
        if_req = 0; mem_ready = 1; mem_rdata = 32'hA5A50001;
        tick();
        check("fl2_rvalid", if_rvalid, 1);
        check("fl2_rdata", if_rdata, 32'hA5A50001);
        mem_ready = 0;
        tick();

        // write with wait states
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("wr_req", mem_req, 1);
            check("wr_we", mem_we, 1);
            check("wr_addr", mem_addr, 32'h200);
            check("wr_wdata", mem_wdata, 32'hCAFEF00D);
            check("wr_rvalid", d_rvalid, 0);
            if (k == 2) begin mem_ready = 1; mem_rdata = 32'hDEADBEEF; end
            tick();
        end
        check("wr_done", d_rvalid, 1);
        check("wr_req_off", mem_req, 0);
        d_req = 0; mem_ready = 0;
        tick();
        check("wr_single", d_rvalid, 0);
        check("wr_idle", mem_req, 0);

        // synchronous reset in the middle of D_BUSY
        d_req = 1; d_we = 0; d_addr = 32'h300;
        tick();
        check("rs_busy", mem_req, 1);
        reset_n = 0;
        tick();
        check("rs_req", mem_req, 0);
        check("rs_addr", mem_addr, 0);
        check("rs_pulses", {if_gnt, if_rvalid, d_rvalid, bus_error}, 0);
        check("rs_rdata", d_rdata, 0);
        reset_n = 1;
        tick();
        check("rs_rearb", mem_req, 1);
        check("rs_rearb_addr", mem_addr, 32'h300);
        mem_ready = 1; mem_rdata = 32'h0BADF00D;
        tick();
        check("rs_rvalid", d_rvalid, 1);
        d_req = 0; mem_ready = 0;
        tick();

`ifdef QRISC32_MEM_ARB_TIMEOUT_EN
        // watchdog: memory never answers
        do_reset();
        d_req = 1; d_addr = 32'h400; mem_rdata = 32'h77;
        tick();
        for (int k = 0; k < TO; k++) begin
            check("to_req", mem_req, 1);
            check("to_berr_early", bus_error, 0);
            tick();
        end
        check("to_req_off", mem_req, 0);
        check("to_berr", bus_error, 1);
        check("to_rvalid", d_rvalid, 1);
        check("to_rdata", d_rdata, 0);
        d_req = 0;
        tick();
        check("to_berr_pulse", bus_error, 0);
`endif

        // randomized traffic against the reference model
        do_reset();
        m_own = 0; m_starv = 0; m_wait = 0; m_drop = 0; m_we = 0;
        m_addr = 0; m_wdata = 0;
        e_req = 0; e_gnt = 0; e_irv = 0; e_drv = 0; e_berr = 0; e_ird = 0; e_drd = 0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_mem_req", mem_req, e_req);
            if (e_req) begin
                check("rnd_mem_addr", mem_addr, m_addr);
                check("rnd_mem_we", mem_we, m_we);
                if (m_own == 2 && m_we) check("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            check("rnd_if_gnt", if_gnt, e_gnt);
            check("rnd_if_rvalid", if_rvalid, e_irv);
            check("rnd_d_rvalid", d_rvalid, e_drv);
            check("rnd_bus_error", bus_error, e_berr);
            if (e_irv) check("rnd_if_rdata", if_rdata, e_ird);
            if (e_drv) check("rnd_d_rdata", d_rdata, e_drd);

            if (if_req && if_gnt) if_req = 0;
            if (!if_req && $urandom_range(99) < 40) begin
                if_req = 1; if_addr = $urandom & ~32'h3;
            end
            if (d_req && d_rvalid) d_req = 0;
            if (!d_req && $urandom_range(99) < 40) begin
                d_req = 1; d_we = 1'($urandom); d_addr = $urandom & ~32'h3; d_wdata = $urandom;
            end
            flush     = ($urandom_range(99) < 12);
            mem_ready = ($urandom_range(99) < 55);
            mem_rdata = $urandom;
            #1 check("rnd_stall", pipe_stall, (d_req && !e_drv) || m_own == 2);

            e_gnt = 0; e_irv = 0; e_drv = 0; e_berr = 0;
            if (m_own == 0) begin
                if (if_req && !flush && (!d_req || m_starv >= SL)) begin
                    m_own = 1; e_gnt = 1; m_addr = if_addr; m_we = 0; m_starv = 0;
                end else begin
                    if (d_req) begin
                        m_own = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                    end
                    if (!if_req) m_starv = 0;
                    else if (d_req && m_starv < SL) m_starv++;
                end
                m_wait = 0;
            end else if (mem_ready || (TO_EN && m_wait == TO - 1)) begin
                m_rd = mem_ready ? mem_rdata : 32'h0;
                if (m_own == 1) begin
                    e_irv = !(m_drop || flush); e_ird = m_rd; m_drop = 0;
                end else begin
                    e_drv = 1; e_drd = m_rd;
                end
                e_berr = !mem_ready;
                m_own  = 0;
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_own == 1 && flush) m_drop = 1;
            end
            e_req = (m_own != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
